mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with a register-file write-back port.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles per operation.
module mul_div_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]    rd_addr,
  output logic             busy,
  output logic             done,
  output logic             RegWrite,
  output logic [AW-1:0]    rw,
  output logic [WIDTH-1:0] WD,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    p_q, p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [AW-1:0]    rw_q, rw_d;
  logic [WIDTH-1:0] wd_q, wd_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [PW-1:0]    step_p;

  // One radix-2 step; p_q holds {hi, lo} = {acc, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    trial   = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
    div_ge  = (trial >= {1'b0, opnd_q});
    div_rem = div_ge ? (trial[WIDTH-1:0] - opnd_q) : trial[WIDTH-1:0];
    if (op_q[1]) begin
      step_p = {div_rem, p_q[WIDTH-2:0], div_ge};
    end else begin
      step_p = {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    rd_d    = rd_q;
    p_d     = p_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    rw_d    = rw_q;
    wd_d    = wd_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          rd_d   = rd_addr;
          cnt_d  = '0;
          busy_d = 1'b1;
          opnd_d = op[1] ? rs2_data : rs1_data;
          p_d    = {{WIDTH{1'b0}}, (op[1] ? rs1_data : rs2_data)};
          if (op[1] && (rs2_data == '0)) begin
            // Divide by zero completes immediately: quotient all-ones, remainder = dividend
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            rw_d    = rd_addr;
            wd_d    = op[0] ? rs1_data : '1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        busy_d = 1'b1;
        p_d    = step_p;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          rw_d    = rd_q;
          wd_d    = op_q[0] ? step_p[PW-1:WIDTH] : step_p[WIDTH-1:0];
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      rd_q    <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      rw_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      rd_q    <= rd_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      rw_q    <= rw_d;
      wd_q    <= wd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign RegWrite    = done_q;
  assign div_by_zero = dbz_q;
  assign rw          = rw_q;
  assign WD          = wd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned LAT   = WIDTH;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [AW-1:0]    rd_addr;
  logic             busy;
  logic             done;
  logic             RegWrite;
  logic [AW-1:0]    rw;
  logic [WIDTH-1:0] WD;
  logic             div_by_zero;

  int n_tests;
  int n_fail;

  mul_div_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .done        (done),
    .RegWrite    (RegWrite),
    .rw          (rw),
    .WD          (WD),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result straight from unsigned arithmetic
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    if (o[1] && b == 0) return o[0] ? a : {WIDTH{1'b1}};
    case (o)
      2'b00:   return prod[WIDTH-1:0];
      2'b01:   return prod[2*WIDTH-1:WIDTH];
      2'b10:   return a / b;
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge; issues one operation and checks every cycle through its completion.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [AW-1:0] rd, input bit hold);
    logic [WIDTH-1:0] exp_wd;
    bit               dbz;
    int               lat;
    exp_wd = model(o, a, b);
    dbz    = o[1] && (b == 0);
    lat    = dbz ? 0 : LAT;
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk);
    #1;
    start    = hold;
    op       = 2'($urandom);
    rs1_data = WIDTH'($urandom);
    rs2_data = WIDTH'($urandom);
    rd_addr  = AW'($urandom);
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(c <= lat));
      check("done", 32'(done), 32'(c == lat));
      check("regwrite", 32'(RegWrite), 32'(c == lat));
      check("div_by_zero", 32'(div_by_zero), 32'(dbz && c == lat));
      if (c >= lat) begin
        check("rw", 32'(rw), 32'(rd));
        check("wd", 32'(WD), 32'(exp_wd));
      end
      if (c == lat + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  // Reset asserted in cycle 8 of a multiply, together with a competing start
  task automatic reset_mid_run();
    start = 1'b1; op = 2'b00; rs1_data = 16'h00FF; rs2_data = 16'h0101; rd_addr = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 8; c++) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_wd", 32'(WD), 32'd0);
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      check("abort_no_write", 32'(RegWrite), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]       ro;
    logic [WIDTH-1:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b1; op = 2'b00;
    rs1_data = 16'h1111; rs2_data = 16'h2222; rd_addr = 4'd3;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_rw", 32'(rw), 32'd0);
    check("reset_wd", 32'(WD), 32'd0);
    rst = 1'b0;

    run_op(2'b00, 16'h1234, 16'h0010, 4'd5, 1'b0);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd1, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd2, 1'b0);
    run_op(2'b10, 16'd100, 16'd7, 4'd3, 1'b0);
    run_op(2'b11, 16'd100, 16'd7, 4'd4, 1'b0);
    run_op(2'b10, 16'h00AB, 16'h0000, 4'd6, 1'b0);
    run_op(2'b11, 16'h00AB, 16'h0000, 4'd7, 1'b0);
    run_op(2'b01, 16'hBEEF, 16'h1234, 4'd8, 1'b1);
    run_op(2'b11, 16'h0042, 16'h0000, 4'd10, 1'b1);
    reset_mid_run();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 16'hFFFF : WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'hFFFF;
        2:       rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      run_op(ro, ra, rb, AW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
